mix_columns_engine: RTL

- Sequential, handshaked AES MixColumns / InvMixColumns engine operating on a full 128-bit state.
- Processes COLS_PER_CYCLE columns per clock, so one block takes 4/COLS_PER_CYCLE compute cycles.
- Sits between ShiftRows and AddRoundKey in the round datapath.
- Generalises the single-column combinational mixer to full-state, multi-cycle, bidirectional operation with valid/ready flow control.

---
 rtl/mix_columns_engine_if.sv | 25 ++
 rtl/mix_columns_engine.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mix_columns_engine_if.sv
// mix_columns_engine_if: block-level handshake bundle for the MixColumns engine.
//   in_valid/in_ready/in_state/in_inverse : input block channel
//   out_valid/out_ready/out_state         : result channel
//   busy                                  : engine holds a block (COMPUTE or DONE)
// master = block source/sink (round datapath), slave = engine.
interface mix_columns_engine_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inverse;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_inverse, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inverse, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: multi-cycle AES MixColumns / InvMixColumns on a 128-bit
// state, COLS_PER_CYCLE (1, 2 or 4) columns per compute cycle.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : mix_columns_engine_if.slave (valid/ready in and out, busy)
// Byte k of a state is state[127-8k -: 8]; column c is bytes 4c..4c+3, row 0 first.
// Optional macro MIX_COLUMNS_INVERSE_EN: when defined, in_inverse selects
// InvMixColumns; when undefined, no inverse logic exists and every block is
// mixed forward (the port stays for interface compatibility).

// One column mixer, purely combinational.
module mix_columns_engine_col (
  input  logic [31:0] col,
  input  logic        inv,
  output logic [31:0] mixed
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, x2, fwd;

  for (genvar r = 0; r < 4; r++) begin : g_row
    assign a[r]   = col[31-8*r -: 8];
    assign x2[r]  = xt(a[r]);
    // 02*a[r] ^ 03*a[r+1] ^ a[r+2] ^ a[r+3]
    assign fwd[r] = x2[r] ^ x2[(r+1)%4] ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
  end

`ifdef MIX_COLUMNS_INVERSE_EN
  logic [3:0][7:0] x4, x8, x9, xb, xd, xe, bwd;
  for (genvar r = 0; r < 4; r++) begin : g_inv
    assign x4[r]  = xt(x2[r]);
    assign x8[r]  = xt(x4[r]);
    assign x9[r]  = x8[r] ^ a[r];
    assign xb[r]  = x8[r] ^ x2[r] ^ a[r];
    assign xd[r]  = x8[r] ^ x4[r] ^ a[r];
    assign xe[r]  = x8[r] ^ x4[r] ^ x2[r];
    assign bwd[r] = xe[r] ^ xb[(r+1)%4] ^ xd[(r+2)%4] ^ x9[(r+3)%4];
    assign mixed[31-8*r -: 8] = inv ? bwd[r] : fwd[r];
  end
`else
  logic unused_inv;
  assign unused_inv = inv;
  for (genvar r = 0; r < 4; r++) begin : g_out
    assign mixed[31-8*r -: 8] = fwd[r];
  end
`endif
endmodule

module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mix_columns_engine_if.slave  bus
);
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
  // idx of the group that finishes column 3 (0 when all four go at once)
  localparam logic [1:0] LAST = 2'((4 - COLS_PER_CYCLE) % 4);

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t       state, state_nx;
  logic [127:0] work;
  logic [1:0]   idx;
  logic         mode;
  logic         accept, last;

  logic [COLS_PER_CYCLE-1:0][1:0]  cidx;
  logic [COLS_PER_CYCLE-1:0][31:0] col_in, col_out;

  assign bus.in_ready  = (state == IDLE) || (state == DONE && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_state = work;

  assign accept = bus.in_valid && bus.in_ready;
  assign last   = (idx == LAST);

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_lane
    assign cidx[g]   = idx + 2'(g);
    // column c sits at bits (3-c)*32 +: 32, and 3-c == ~c for 2 bits
    assign col_in[g] = work[{~cidx[g], 5'd0} +: 32];
    mix_columns_engine_col u_col (
      .col   (col_in[g]),
      .inv   (mode),
      .mixed (col_out[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nx = COMPUTE;
      COMPUTE: if (last)         state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = bus.in_valid ? COMPUTE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      work <= '0;
      idx  <= '0;
    end else if (accept) begin
      work <= bus.in_state;
      idx  <= '0;
    end else if (state == COMPUTE) begin
      for (int g = 0; g < COLS_PER_CYCLE; g++)
        work[{~cidx[g], 5'd0} +: 32] <= col_out[g];
      idx <= idx + STEP;
    end
  end

`ifdef MIX_COLUMNS_INVERSE_EN
  // mode is latched only at the input handshake, so in_inverse is a don't-care
  // while a block is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       mode <= 1'b0;
    else if (accept) mode <= bus.in_inverse;
  end
`else
  logic unused_in_inverse;
  assign unused_in_inverse = bus.in_inverse;
  assign mode = 1'b0;
`endif
endmodule
